// File: rtl/core_encode.sv
// core_encode: RV32I (+F subset, +custom IN/OUT) instruction encoder that
// feeds a 4-entry output FIFO.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high while the FIFO has room
//   op, rd, rs1, rs2, imm operation index (0..47 legal) and operand fields;
//                         imm is a byte offset for branches and jumps
//   out_valid / out_ready FIFO-head handshake; out_inst is the encoded word at the head
//   count                 FIFO occupancy, 0..4
//   err, err_clr          sticky error flag and its clear
//   err_cnt               rejected-request count, saturates at 255
//   out_cnt               words delivered, wraps at 16 bits
module core_encode (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         op,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic signed [31:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [2:0]         count,
    output logic               err,
    input  logic               err_clr,
    output logic [7:0]         err_cnt,
    output logic [15:0]        out_cnt
);

    typedef enum logic [2:0] {
        FMT_I, FMT_SH, FMT_R, FMT_B, FMT_S, FMT_J, FMT_U, FMT_IO
    } fmt_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
    localparam logic [6:0] OPC_FP     = 7'b1010011;
    localparam logic [6:0] OPC_IO     = 7'b0000001;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    fmt_t        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        op_ok;
    logic        range_ok;
    logic [31:0] word;

    // Operation decode: format plus opcode/func3/func7 for each index.
    always_comb begin
        fmt   = FMT_R;
        opc   = '0;
        f3    = '0;
        f7    = '0;
        op_ok = 1'b1;
        case (op)
            6'd0:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b000; end
            6'd1:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b010; end
            6'd2:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b011; end
            6'd3:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b100; end
            6'd4:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b110; end
            6'd5:  begin fmt = FMT_I;  opc = OPC_OPIMM; f3 = 3'b111; end
            6'd6:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b001; end
            6'd7:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; end
            6'd8:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; f7 = F7_ALT; end
            6'd9:  begin opc = OPC_OP; f3 = 3'b000; end
            6'd10: begin opc = OPC_OP; f3 = 3'b000; f7 = F7_ALT; end
            6'd11: begin opc = OPC_OP; f3 = 3'b001; end
            6'd12: begin opc = OPC_OP; f3 = 3'b010; end
            6'd13: begin opc = OPC_OP; f3 = 3'b011; end
            6'd14: begin opc = OPC_OP; f3 = 3'b100; end
            6'd15: begin opc = OPC_OP; f3 = 3'b101; end
            6'd16: begin opc = OPC_OP; f3 = 3'b101; f7 = F7_ALT; end
            6'd17: begin opc = OPC_OP; f3 = 3'b110; end
            6'd18: begin opc = OPC_OP; f3 = 3'b111; end
            6'd19: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b000; end
            6'd20: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b001; end
            6'd21: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b100; end
            6'd22: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b101; end
            6'd23: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b110; end
            6'd24: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b111; end
            6'd25: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b000; end
            6'd26: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b001; end
            6'd27: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b010; end
            6'd28: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b100; end
            6'd29: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b101; end
            6'd30: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b000; end
            6'd31: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b001; end
            6'd32: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b010; end
            6'd33: begin fmt = FMT_I; opc = OPC_JALR; f3 = 3'b000; end
            6'd34: begin fmt = FMT_J; opc = OPC_JAL; end
            6'd35: begin fmt = FMT_U; opc = OPC_AUIPC; end
            6'd36: begin fmt = FMT_U; opc = OPC_LUI; end
            6'd37: begin fmt = FMT_I; opc = OPC_FLW; f3 = 3'b010; end
            6'd38: begin fmt = FMT_S; opc = OPC_FSW; f3 = 3'b010; end
            6'd39: begin opc = OPC_FP; f7 = 7'b0000000; end
            6'd40: begin opc = OPC_FP; f7 = 7'b0000100; end
            6'd41: begin opc = OPC_FP; f7 = 7'b0001000; end
            6'd42: begin opc = OPC_FP; f7 = 7'b0001100; end
            6'd43: begin opc = OPC_FP; f7 = 7'b1010000; f3 = 3'b010; end
            6'd44: begin opc = OPC_FP; f7 = 7'b1010000; f3 = 3'b001; end
            6'd45: begin opc = OPC_FP; f7 = 7'b1010000; f3 = 3'b000; end
            6'd46: begin fmt = FMT_IO; opc = OPC_IO; f3 = 3'b000; end
            6'd47: begin fmt = FMT_IO; opc = OPC_IO; f3 = 3'b001; end
            default: op_ok = 1'b0;
        endcase
    end

    // Field assembly and immediate range check. A field is representable
    // when every bit above its sign bit repeats that sign bit.
    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        case (fmt)
            FMT_I: begin
                word     = {imm[11:0], rs1, f3, rd, opc};
                range_ok = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_SH: begin
                word     = {f7, imm[4:0], rs1, f3, rd, opc};
                range_ok = ~(|imm[31:5]);
            end
            FMT_R:  word = {f7, rs2, rs1, f3, rd, opc};
            FMT_B: begin
                word     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                range_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            end
            FMT_S: begin
                word     = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                range_ok = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_J: begin
                word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                range_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            end
            FMT_U: begin
                word     = {imm[31:12], rd, opc};
                range_ok = ~(|imm[11:0]);
            end
            FMT_IO: word = {17'b0, f3, rd, opc};
            default: word = '0;
        endcase
    end

    logic [31:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic        accept;
    logic        push;
    logic        pop;
    logic        bad;

    assign in_ready  = (count != 3'd4);
    assign out_valid = (count != 3'd0);
    // Gate the head with occupancy so an empty or reset FIFO reads as zero
    // without clearing the storage array itself.
    assign out_inst  = out_valid ? fifo_mem[rd_ptr] : 32'd0;
    assign accept    = in_valid & in_ready;
    assign push      = accept & op_ok & range_ok;
    assign bad       = accept & ~(op_ok & range_ok);
    assign pop       = out_valid & out_ready;

    // Storage stage: data only, no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= word;
    end

    // Control stage: pointers, occupancy, counters, error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_cnt <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 2'd1;
                out_cnt <= out_cnt + 16'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
            // A new rejection in the clearing cycle counts as the first one.
            if (err_clr) begin
                err     <= bad;
                err_cnt <= bad ? 8'd1 : 8'd0;
            end else if (bad) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_core_encode.sv
module tb_core_encode;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         op;
    logic [4:0]         rd, rs1, rs2;
    logic signed [31:0] imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic [2:0]         count;
    logic               err;
    logic               err_clr;
    logic [7:0]         err_cnt;
    logic [15:0]        out_cnt;

    int checks   = 0;
    int failures = 0;

    core_encode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .count(count), .err(err), .err_clr(err_clr), .err_cnt(err_cnt),
        .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    // Directed encode vectors with hand-assembled expected words.
    localparam int NV = 12;
    localparam logic [5:0]  V_OP  [NV] = '{6'd0, 6'd10, 6'd19, 6'd36, 6'd8, 6'd34,
                                           6'd32, 6'd39, 6'd43, 6'd47, 6'd0, 6'd46};
    localparam logic [4:0]  V_RD  [NV] = '{5'd1, 5'd3, 5'd7, 5'd5, 5'd2, 5'd1,
                                           5'd0, 5'd1, 5'd1, 5'd7, 5'd1, 5'd3};
    localparam logic [4:0]  V_RS1 [NV] = '{5'd0, 5'd1, 5'd1, 5'd31, 5'd3, 5'd4,
                                           5'd2, 5'd2, 5'd2, 5'd31, 5'd0, 5'd0};
    localparam logic [4:0]  V_RS2 [NV] = '{5'd9, 5'd2, 5'd2, 5'd31, 5'd0, 5'd4,
                                           5'd5, 5'd3, 5'd3, 5'd31, 5'd0, 5'd0};
    localparam logic [31:0] V_IMM [NV] = '{32'd5, 32'd0, 32'hFFFFFFFC, 32'h12345000,
                                           32'd7, 32'd8, 32'd12, 32'd0, 32'd0, 32'd0,
                                           32'hFFFFF800, 32'd0};
    localparam logic [31:0] V_EXP [NV] = '{32'h00500093, 32'h402081B3, 32'hFE208EE3,
                                           32'h123452B7, 32'h4071D113, 32'h008000EF,
                                           32'h00512623, 32'h003100D3, 32'hA03120D3,
                                           32'h00001381, 32'h80000093, 32'h00000181};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] i);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = i;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 32'd0) begin
            failures++;
            $display("FAIL reset_fifo: count=%0d out_valid=%b out_inst=%h, want 0/0/0", count, out_valid, out_inst);
        end
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0 || out_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt: err=%b err_cnt=%0d out_cnt=%0d, want 0/0/0", err, err_cnt, out_cnt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_encode();
        for (int v = 0; v < NV; v++) begin
            drive(V_OP[v], V_RD[v], V_RS1[v], V_RS2[v], V_IMM[v]);
            checks++;
            if (out_valid !== 1'b1 || out_inst !== V_EXP[v]) begin
                failures++;
                $display("FAIL encode_%0d: out_valid=%b out_inst=%h, want 1/%h", v, out_valid, out_inst, V_EXP[v]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (count !== 3'd0) begin
                failures++;
                $display("FAIL encode_pop_%0d: count=%0d want 0", v, count);
            end
        end
    endtask

    task automatic test_errors();
        drive(6'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
        checks++;
        if (count !== 3'd0 || err !== 1'b1 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL err_addi_range: count=%0d err=%b err_cnt=%0d, want 0/1/1", count, err, err_cnt);
        end
        drive(6'd50, 5'd1, 5'd0, 5'd0, 32'd0);
        checks++;
        if (count !== 3'd0 || err_cnt !== 8'd2) begin
            failures++;
            $display("FAIL err_illegal_op: count=%0d err_cnt=%0d, want 0/2", count, err_cnt);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL err_clear: err=%b err_cnt=%0d, want 0/0", err, err_cnt);
        end
        drive(6'd19, 5'd0, 5'd1, 5'd2, 32'd3);          // odd branch offset
        drive(6'd6,  5'd1, 5'd1, 5'd0, 32'd32);         // shift amount too large
        drive(6'd34, 5'd1, 5'd0, 5'd0, 32'h00100000);   // JAL offset out of range
        drive(6'd36, 5'd1, 5'd0, 5'd0, 32'h00001001);   // LUI low bits set
        checks++;
        if (count !== 3'd0 || err !== 1'b1 || err_cnt !== 8'd4) begin
            failures++;
            $display("FAIL err_ranges: count=%0d err=%b err_cnt=%0d, want 0/1/4", count, err, err_cnt);
        end
        err_clr = 1'b1;
        drive(6'd63, 5'd1, 5'd0, 5'd0, 32'd0);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL err_clr_vs_new: err=%b err_cnt=%0d, want 1/1", err, err_cnt);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(6'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        out_ready = 1'b1;
        drive(6'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        checks++;
        if (count !== 3'd1 || out_inst !== 32'h00200093) begin
            failures++;
            $display("FAIL b2b_push_pop: count=%0d out_inst=%h, want 1/00200093", count, out_inst);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: count=%0d out_valid=%b, want 0/0", count, out_valid);
        end
    endtask

    task automatic test_full_and_reset();
        logic [31:0] w;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(6'd0, 5'd1, 5'd0, 5'd0, k);
            if (k == 4) begin
                checks++;
                if (count !== 3'd4 || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_after4: count=%0d in_ready=%b, want 4/0", count, in_ready);
                end
            end
        end
        checks++;
        if (count !== 3'd4 || out_inst !== 32'h00100093) begin
            failures++;
            $display("FAIL full_ignore5: count=%0d head=%h, want 4/00100093", count, out_inst);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = ((i + 1) << 20) | 32'h93;
            checks++;
            if (out_valid !== 1'b1 || out_inst !== w) begin
                failures++;
                $display("FAIL drain_%0d: out_valid=%b out_inst=%h, want 1/%h", i, out_valid, out_inst, w);
            end
            tick();
        end
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_cnt !== 16'd4) begin
            failures++;
            $display("FAIL drain_done: count=%0d out_valid=%b out_cnt=%0d, want 0/0/4", count, out_valid, out_cnt);
        end
        out_ready = 1'b0;
        for (int k = 6; k <= 8; k++) drive(6'd0, 5'd1, 5'd0, 5'd0, k);
        out_ready = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_inst !== 32'd0 || out_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_drain: out_valid=%b count=%0d out_inst=%h out_cnt=%0d, want 0/0/0/0",
                     out_valid, count, out_inst, out_cnt);
        end
        #1;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_reset: out_valid=%b count=%0d in_ready=%b, want 0/0/1", out_valid, count, in_ready);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        test_reset();
        test_encode();
        test_errors();
        test_back_to_back();
        test_full_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_encode.md
CORE_ENCODE -- requirements
Module: core_encode

Interface
REQ-001 SHALL provide ports: CLK in 1 clock; RST_N in 1 asynchronous active-low reset.
REQ-002 SHALL provide ports: IN_VALID in 1 request valid; IN_READY out 1 encoder can accept.
REQ-003 SHALL provide ports: OP in 6 operation index; RD in 5; RS1 in 5; RS2 in 5; IMM in 32 immediate, byte offset for branch/jump.
REQ-004 SHALL provide ports: OUT_VALID out 1; OUT_READY in 1; OUT_INST out 32 encoded RV32 word (FIFO head).
REQ-005 SHALL provide ports: COUNT out 3 FIFO occupancy 0..4; ERR out 1 sticky error; ERR_CLR in 1; ERR_CNT out 8; OUT_CNT out 16 words delivered.

Function
REQ-006 SHALL map OP 0..47, in order:
- ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
- ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
- BEQ BNE BLT BGE BLTU BGEU
- LB LH LW LBU LHU SB SH SW
- JALR JAL AUIPC LUI
- FLW FSW FADDS FSUBS FMULS FDIVS FEQS FLTS FLES
- IN OUT
OP 48..63 SHALL be illegal.
REQ-007 SHALL use standard RV32I opcode/func3/func7; SRAI/SUB/SRA func7=0100000, else 0000000.
REQ-008 SHALL encode FLW 0000111/010, FSW 0100111/010 (I/S forms).
REQ-009 SHALL encode FP ops with opcode 1010011 and func7: FADDS 0000000, FSUBS 0000100, FMULS 0001000, FDIVS 0001100, FEQS/FLTS/FLES 1010000.
REQ-010 SHALL set FP func3: FEQS 010, FLTS 001, FLES 000, arithmetic 000.
REQ-011 SHALL encode IN/OUT with opcode 0000001, func3 000/001, RD in [11:7], all other bits 0.
REQ-012 SHALL zero register fields not used by the format (e.g. RS2 for I-type, RS1/RS2 for U/J).
REQ-013 SHALL raise a range error when:
- I/S/JALR/loads: IMM[31:11] not all equal.
- Shift-immediates: IMM[31:5]!=0.
- Branch: IMM[31:12] not all equal, or IMM[0]=1.
- JAL: IMM[31:20] not all equal, or IMM[0]=1.
- LUI/AUIPC: IMM[11:0]!=0; IMM[31:12] used directly.
REQ-014 IN_READY SHALL be 1 iff COUNT<4; no push when full even if a pop occurs the same cycle.
REQ-015 On IN_VALID&IN_READY with legal OP and range: word SHALL be pushed into a 4-entry FIFO at that edge; OUT_VALID visible the following cycle (1-cycle latency).
REQ-016 On accepted illegal OP or range error: nothing pushed; ERR set to 1; ERR_CNT+1, saturating at 255.
REQ-017 OUT_VALID SHALL be COUNT!=0; OUT_INST SHALL hold the head stable while OUT_VALID&!OUT_READY.
REQ-018 OUT_VALID&OUT_READY SHALL pop the head and increment OUT_CNT, wrapping 0xFFFF->0.
REQ-019 Simultaneous push and pop with COUNT in 1..3 SHALL leave COUNT unchanged; FIFO order SHALL be preserved.
REQ-020 ERR_CLR SHALL clear ERR and ERR_CNT; a same-cycle new error wins (ERR=1, ERR_CNT=1).
REQ-021 IN_* SHALL be ignored while IN_READY=0.

Reset
REQ-022 RST_N low SHALL immediately force COUNT=0, OUT_VALID=0, ERR=0, ERR_CNT=0, OUT_CNT=0, FIFO pointers 0, OUT_INST=0; IN_READY=1 after release.
REQ-023 Reset mid-transfer SHALL discard all FIFO contents with no partial output.

Verification
REQ-024 ADDI RD=1 RS1=0 IMM=5 -> OUT_INST=0x00500093 one cycle later.
REQ-025 SUB RD=3 RS1=1 RS2=2 -> 0x402081B3.
REQ-026 BEQ RS1=1 RS2=2 IMM=-4 -> 0xFE208EE3.
REQ-027 LUI RD=5 IMM=0x12345000 -> 0x123452B7.
REQ-028 ADDI IMM=0x800 -> no push, ERR=1, ERR_CNT=1; OP=50 -> ERR_CNT=2; ERR_CLR -> both 0.
REQ-029 OUT_READY=0, push 5 legal words -> IN_READY=0 after 4th, COUNT=4; OUT_READY=1 -> 4 words in order, OUT_CNT=4; assert RST_N low mid-drain -> OUT_VALID=0 at once.
